// File: rtl/cache_pkg.sv
// Shared constants and types for the cache line adaptor.
package cache_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int OFS     = $clog2(LINE_W / 8);
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Byte-offset bits within a line; cleared to line-align an address.
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((64'd1 << OFS) - 64'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;

  // Line-align a byte address by clearing the in-line offset bits.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return a & ~OFS_MASK;
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor. One line fill or writeback is split
// into BEATS beats of BURST_W bits; the cache side sees one request and one
// resp_o pulse. Optional performance counters are built when the macro
// CACHELINE_ADAPTOR_PERF_EN is defined; otherwise the perf ports read 0.
module cacheline_adaptor
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i,
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_wr_cnt,
  output logic [31:0]       perf_stall_cnt
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adaptor_state_t   state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  logic             last_beat_s;
  line_t            line_r;     // fill buffer, drives line_o
  line_t            wb_line_r;  // latched writeback line
  logic [ADDR_W-1:0] address_r;
  beat_t            burst_r;
  logic             read_r;
  logic             write_r;
  logic             resp_r;

  // Beat counter helpers shared by the read and write paths.
  always_comb begin
    next_cnt_s  = cnt_r + CNT_W'(1);
    last_beat_s = (cnt_r == LAST_BEAT);
  end

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      line_r    <= '0;
      wb_line_r <= '0;
      address_r <= '0;
      burst_r   <= '0;
      read_r    <= 1'b0;
      write_r   <= 1'b0;
      resp_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Writeback wins when both requests are raised together.
          if (write_i) begin
            wb_line_r <= line_i;
            address_r <= align_addr(address_i);
            burst_r   <= line_i[BURST_W-1:0];
            cnt_r     <= '0;
            write_r   <= 1'b1;
            state_r   <= WRITE;
          end else if (read_i) begin
            address_r <= align_addr(address_i);
            cnt_r     <= '0;
            read_r    <= 1'b1;
            state_r   <= READ;
          end else begin
            state_r   <= IDLE;
          end
        end
        READ: begin
          if (resp_i) begin
            line_r[int'(cnt_r)*BURST_W +: BURST_W] <= burst_i;
            if (last_beat_s) begin
              cnt_r   <= '0;
              read_r  <= 1'b0;
              resp_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              cnt_r   <= next_cnt_s;
            end
          end else begin
            state_r <= READ;
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (last_beat_s) begin
              cnt_r   <= '0;
              write_r <= 1'b0;
              burst_r <= '0;
              resp_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              cnt_r   <= next_cnt_s;
              burst_r <= wb_line_r[int'(next_cnt_s)*BURST_W +: BURST_W];
            end
          end else begin
            state_r <= WRITE;
          end
        end
        DONE: begin
          resp_r    <= 1'b0;
          address_r <= '0;
          state_r   <= IDLE;
        end
        default: begin
          cnt_r     <= '0;
          address_r <= '0;
          burst_r   <= '0;
          read_r    <= 1'b0;
          write_r   <= 1'b0;
          resp_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign line_o    = line_r;
  assign address_o = address_r;
  assign burst_o   = burst_r;
  assign read_o    = read_r;
  assign write_o   = write_r;
  assign resp_o    = resp_r;

`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic [31:0] perf_rd_r;
  logic [31:0] perf_wr_r;
  logic [31:0] perf_stall_r;

  // Completed-transaction and stall counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_r    <= 32'd0;
      perf_wr_r    <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (state_r == READ && resp_i && last_beat_s) begin
        perf_rd_r <= perf_rd_r + 32'd1;
      end
      if (state_r == WRITE && resp_i && last_beat_s) begin
        perf_wr_r <= perf_wr_r + 32'd1;
      end
      if ((state_r == READ || state_r == WRITE) && !resp_i) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_rd_cnt    = perf_rd_r;
  assign perf_wr_cnt    = perf_wr_r;
  assign perf_stall_cnt = perf_stall_r;
`else
  assign perf_rd_cnt    = 32'd0;
  assign perf_wr_cnt    = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits between the cache datapath (data array plus controller) and the physical memory bus.
- Converts one LINE_W-bit cache line fill or writeback into a BEATS-long burst of BURST_W-bit beats.
- Presents a single-request, single-response interface to the cache side.
- Its assembled fill line drives the data array's datain; its writeback line comes from the data array's dataout.

Parameters:
- LINE_W, 256: cache line width in bits.
- BURST_W, 64: memory beat width in bits; LINE_W must be an integer multiple of it.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- line_i  in  LINE_W  writeback line from the data array; sampled when write_i is accepted.
- line_o  out  LINE_W  assembled fill line.
- address_i  in  ADDR_W  cache-side byte address.
- read_i  in  1  line fill request.
- write_i  in  1  line writeback request.
- resp_o  out  1  one-cycle completion pulse.
- burst_i  in  BURST_W  memory read beat.
- burst_o  out  BURST_W  memory write beat.
- address_o  out  ADDR_W  line-aligned memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat strobe.
- perf_rd_cnt  out  32  completed fills.
- perf_wr_cnt  out  32  completed writebacks.
- perf_stall_cnt  out  32  busy cycles without resp_i.

Behaviour:
- BEATS = LINE_W/BURST_W (4 at defaults); OFS = log2(LINE_W/8) (5).
- Reset (async, rst_n low):
  - State goes to IDLE; beat counter, line buffer and latched address clear to 0.
  - All outputs are 0.
  - Takes effect immediately, including mid-burst; any partial burst is abandoned and no resp_o is issued.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1: latch line_i and address_i; next state WRITE. write_i has priority if read_i and write_i are both 1.
  - Else read_i=1: latch address_i; next state READ.
  - resp_i is ignored in IDLE.
- Address:
  - address_o = latched address with bits [OFS-1:0] forced to 0.
  - address_o is held for the whole transaction and is 0 in IDLE.
- READ:
  - read_o=1 continuously.
  - Each cycle resp_i=1, burst_i is stored into line buffer slice [cnt*BURST_W +: BURST_W] and cnt increments.
  - Beats may be non-consecutive; cycles with resp_i=0 hold state.
  - On the beat where cnt==BEATS-1: cnt wraps to 0 and next state is DONE. read_o drops the cycle after that beat.
- WRITE:
  - write_o=1 continuously.
  - burst_o = latched line slice [cnt*BURST_W +: BURST_W]; advances on each resp_i=1.
  - The last beat leads to DONE, with the same wrap rule as READ.
  - burst_o = 0 outside WRITE.
- DONE:
  - resp_o=1 for exactly one cycle, then IDLE.
  - read_i/write_i are ignored in DONE; a request held high is accepted in the following IDLE cycle.
- line_o:
  - Driven from the line buffer.
  - Valid from the DONE cycle of a read; holds until the next READ begins overwriting beats.
- Requests arriving during READ, WRITE or DONE are not queued.
- Latency: fill or writeback = 1 (accept) + BEATS beat cycles (minimum) + 1 (DONE). Minimum 6 cycles at defaults.

Optional Feature:
- CACHELINE_ADAPTOR_PERF_EN defined:
  - perf_rd_cnt increments on each read DONE.
  - perf_wr_cnt increments on each write DONE.
  - perf_stall_cnt increments on each READ/WRITE cycle with resp_i=0.
  - All counters are 32-bit wrapping and cleared by rst_n.
- Undefined: the three perf ports are tied to 0 and no counter flops are synthesized.

Decomposition:
- Package cache_pkg holds:
  - LINE_W, BURST_W, ADDR_W, BEATS and OFS constants;
  - adaptor_state_t enum {IDLE, READ, WRITE, DONE};
  - line_t and beat_t typedefs.
- No sub-module; the FSM, counter and line buffer stay in one module.

Test Plan:
- Back-to-back read:
  - Stimulus: read_i=1, address_i=0x1234_5678; resp_i high for 4 consecutive cycles with burst_i = 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Expect: address_o=0x1234_5660; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; one resp_o pulse 6 cycles after accept.
- Gapped write:
  - Stimulus: write_i=1, line_i=256'h0123...; resp_i pattern 1,0,0,1,1,0,1.
  - Expect: burst_o steps through line_i slices 0..3 only on resp_i cycles; write_o low after the 4th beat; resp_o one cycle; perf_stall_cnt=3 when PERF_EN is defined.
- Simultaneous requests:
  - Stimulus: read_i=1 and write_i=1 in IDLE.
  - Expect: WRITE path is taken; read_o stays 0.
- Reset mid-burst:
  - Stimulus: rst_n low after 2 read beats.
  - Expect: all outputs 0 in the same cycle, no resp_o; a following full read returns a correct line.
- Stray resp_i:
  - Stimulus: resp_i=1 in IDLE.
  - Expect: no state change, line_o unchanged, no resp_o.
- Optional feature disabled:
  - Stimulus: 3 reads and 2 writes with CACHELINE_ADAPTOR_PERF_EN undefined.
  - Expect: all perf ports read 0. With the macro defined: perf_rd_cnt=3, perf_wr_cnt=2.
